// File: rtl/sync_fifo_pro_if.sv
// rtl/sync_fifo_pro_if.sv - handshake, data and status bundle for sync_fifo_pro
interface sync_fifo_pro_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             winc;
  logic [WIDTH-1:0] wdata;
  logic             rinc;
  logic             clr_err;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             wfull;
  logic             rempty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output winc, wdata, rinc, clr_err,
    input  rdata, rvalid, wfull, rempty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc, clr_err,
    output rdata, rvalid, wfull, rempty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_pro.sv
// rtl/sync_fifo_pro.sv - single-clock FIFO with registered or FWFT read and sticky error flags
module sync_fifo_pro #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_pro_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_L   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L   = CW'(AE_LEVEL);
  localparam logic [CW-1:0] FULL_L = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wptr;
  logic [CW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_af;
  logic             r_ae;
  logic             r_ovf;
  logic             r_udf;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_head;

  // Acceptance uses the registered flags, so full/empty are judged before the edge.
  assign w_wr_acc = bus.winc && !r_full;
  assign w_rd_acc = bus.rinc && !r_empty;
  assign w_head   = r_mem[r_rptr[AW-1:0]];

  // Occupancy after this edge; flags are derived from it so they never lag count.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Storage is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[r_wptr[AW-1:0]] <= bus.wdata;
    end
  end

  // Pointers, occupancy and level flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + CW'(1);
      if (w_rd_acc) r_rptr <= r_rptr + CW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_L);
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= AF_L);
      r_ae    <= (w_count_nxt <= AE_L);
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (bus.winc && r_full)  || (r_ovf && !bus.clr_err);
      r_udf <= (bus.rinc && r_empty) || (r_udf && !bus.clr_err);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; masked to zero while empty.
      assign bus.rdata  = r_empty ? '0 : w_head;
      assign bus.rvalid = !r_empty;
    end else begin : g_reg
      logic [WIDTH-1:0] r_rdata;
      logic             r_rvalid;

      // Registered read: rdata loads on a pop and holds otherwise; rvalid pulses one cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_rd_acc;
          if (w_rd_acc) r_rdata <= w_head;
        end
      end

      assign bus.rdata  = r_rdata;
      assign bus.rvalid = r_rvalid;
    end
  endgenerate

  assign bus.wfull        = r_full;
  assign bus.rempty       = r_empty;
  assign bus.almost_full  = r_af;
  assign bus.almost_empty = r_ae;
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;
endmodule

// File: doc/sync_fifo_pro.md
SYNC_FIFO_PRO -- requirements
Module: sync_fifo_pro

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, word capacity; power of two, >=4.
REQ-003 SHALL have parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-2, almost-full threshold in words.
REQ-005 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold in words.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-008 SHALL have port winc  input  1  write request.
REQ-009 SHALL have port wdata  input  WIDTH  write data.
REQ-010 SHALL have port rinc  input  1  read request (FWFT: pop/acknowledge).
REQ-011 SHALL have port rdata  output  WIDTH  read data.
REQ-012 SHALL have port rvalid  output  1  rdata holds a valid word.
REQ-013 SHALL have port wfull  output  1  occupancy == DEPTH.
REQ-014 SHALL have port rempty  output  1  occupancy == 0.
REQ-015 SHALL have port almost_full  output  1  occupancy >= AF_LEVEL.
REQ-016 SHALL have port almost_empty  output  1  occupancy <= AE_LEVEL.
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-018 SHALL have port overflow  output  1  sticky: write attempted while full.
REQ-019 SHALL have port underflow  output  1  sticky: read attempted while empty.
REQ-020 SHALL have port clr_err  input  1  clears overflow and underflow.

Function
REQ-021 Write SHALL be accepted iff winc && !wfull; accepted word stored at write pointer, pointer +1 mod DEPTH.
REQ-022 Read SHALL be accepted iff rinc && !rempty; read pointer +1 mod DEPTH.
REQ-023 Pointers SHALL be $clog2(DEPTH)+1 bits; extra MSB distinguishes full from empty on wrap.
REQ-024 count SHALL be registered: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-025 wfull, rempty, almost_full, almost_empty SHALL be registered and reflect the count value after the same edge (no one-cycle lag).
REQ-026 Simultaneous winc/rinc when full: read accepted, write rejected (flags evaluated pre-edge); count -> DEPTH-1.
REQ-027 Simultaneous winc/rinc when empty: write accepted, read rejected; count -> 1.
REQ-028 Simultaneous accepted read and write otherwise: both performed, count unchanged, flags unchanged.
REQ-029 FWFT=0: on accepted read, rdata SHALL be loaded with head word at that edge and rvalid=1 for exactly the following cycle; rdata holds value when no read; rvalid=0 otherwise.
REQ-030 FWFT=1: rdata SHALL equal the head word combinationally whenever !rempty; rvalid SHALL equal !rempty; rinc pops head.
REQ-031 FWFT=1: word written into empty FIFO SHALL appear on rdata with rvalid=1 in the cycle after the write edge.
REQ-032 overflow SHALL set on any edge with winc && wfull; underflow on rinc && rempty; both hold until clr_err.
REQ-033 If clr_err and a new error condition coincide, the set SHALL win.
REQ-034 Rejected requests SHALL NOT alter pointers, storage, count or rdata.

Reset
REQ-035 While rst=1 at a clock edge: pointers=0, count=0, rempty=1, wfull=0, almost_empty=1, almost_full=0, rvalid=0, rdata=0, overflow=0, underflow=0.
REQ-036 rst SHALL override winc, rinc and clr_err in the same cycle; storage contents need not be cleared.
REQ-037 Reset mid-operation SHALL discard all stored words; first read after reset returns first word written after reset.

Verification
REQ-038 Reset, then idle -> rempty=1, count=0, almost_empty=1, rvalid=0, flags 0.
REQ-039 DEPTH=16: write 0x00..0x0F, then extra write 0xAA -> wfull=1 after 16th edge, almost_full=1 at count 14, 0xAA dropped, overflow=1.
REQ-040 FWFT=0: fill 16, read 16 -> rdata 0x00..0x0F in order, each with rvalid one cycle after rinc; 17th rinc -> underflow=1, rdata stays 0x0F.
REQ-041 Full FIFO, winc+rinc same cycle -> count=15, wfull=0, next read returns old head+1; empty FIFO winc+rinc -> count=1.
REQ-042 FWFT=1: write 0x5A to empty -> next cycle rdata=0x5A, rvalid=1 without rinc; rinc -> rempty=1.
REQ-043 Pointer wrap: 40 interleaved write/read pairs at count 3 -> data order preserved, count stays 3; rst asserted mid-stream -> count=0, rempty=1 next cycle.
